// File: rtl/ext_tid_alloc_ipa_if.sv
// Request/grant and release handshake between the MCHAN external command path
// and the EXT TID allocator.
interface ext_tid_alloc_ipa_if #(
  parameter int unsigned EXT_TID_WIDTH = 4
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     tid_valid;
  logic [EXT_TID_WIDTH-1:0] tid;
  logic                     rel_valid;
  logic [EXT_TID_WIDTH-1:0] rel_tid;

  modport master (
    output req_valid, rel_valid, rel_tid,
    input  req_ready, tid_valid, tid
  );

  modport slave (
    input  req_valid, rel_valid, rel_tid,
    output req_ready, tid_valid, tid
  );
endinterface

// File: rtl/ext_tid_alloc_ipa.sv
// EXT TID allocator for the MCHAN external opcode buffer: grants the lowest free
// TID, recycles TIDs on response completion, throttles and supports flush/drain.
module ext_tid_alloc_ipa #(
  parameter int unsigned EXT_TID_WIDTH   = 4,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  ext_tid_alloc_ipa_if.slave     tid_bus,
  input  logic                   flush_req_i,
  output logic                   flush_ack_o,
  output logic [EXT_TID_WIDTH:0] outstanding_o,
  output logic                   err_o
);

  localparam int unsigned NTID  = 2 ** EXT_TID_WIDTH;
  localparam int unsigned CNT_W = EXT_TID_WIDTH + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [NTID-1:0]  ONE_HOT0 = NTID'(1);

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > NTID) begin : g_bad_max
    $error("ext_tid_alloc_ipa: MAX_OUTSTANDING must be in 1..2**EXT_TID_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_t;

  state_t                   r_state;
  logic [NTID-1:0]          r_busy;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_err;

  logic [EXT_TID_WIDTH-1:0] w_free_tid;
  logic                     w_any_free;
  logic                     w_ready;
  logic                     w_grant;
  logic                     w_rel_hit;
  logic                     w_rel_legal;
  logic                     w_rel_illegal;
  logic [NTID-1:0]          w_set_mask;
  logic [NTID-1:0]          w_clr_mask;
  logic [CNT_W-1:0]         w_cnt_nxt;

  // Lowest-index free TID; scanning downward lets the lowest index win.
  always_comb begin
    w_free_tid = '0;
    w_any_free = 1'b0;
    for (int i = int'(NTID) - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_tid = EXT_TID_WIDTH'(i);
        w_any_free = 1'b1;
      end
    end
  end

  assign w_ready       = (r_state == ST_RUN) && (r_cnt < MAX_CNT) && w_any_free;
  assign w_grant       = tid_bus.req_valid && w_ready;
  assign w_rel_hit     = r_busy[tid_bus.rel_tid];
  assign w_rel_legal   = tid_bus.rel_valid && w_rel_hit;
  assign w_rel_illegal = tid_bus.rel_valid && !w_rel_hit;

  // A released TID is busy during its release cycle, so the grant never picks it.
  assign w_set_mask = w_grant     ? (ONE_HOT0 << w_free_tid)      : '0;
  assign w_clr_mask = w_rel_legal ? (ONE_HOT0 << tid_bus.rel_tid) : '0;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_grant && !w_rel_legal) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else if (w_rel_legal && !w_grant) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= (r_busy | w_set_mask) & ~w_clr_mask;
      r_cnt  <= w_cnt_nxt;
      r_err  <= w_rel_illegal;
    end
  end

  // Flush/drain control; drain completion looks at the registered count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (flush_req_i) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!flush_req_i) begin
            r_state <= ST_RUN;
          end else if (r_cnt == '0) begin
            r_state <= ST_DRAINED;
          end
        end
        ST_DRAINED: begin
          if (!flush_req_i) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign tid_bus.req_ready = w_ready;
  assign tid_bus.tid_valid = w_grant;
  assign tid_bus.tid       = w_free_tid;
  assign flush_ack_o       = (r_state == ST_DRAINED);
  assign outstanding_o     = r_cnt;
  assign err_o             = r_err;

endmodule
